pipe_ctrl: RTL and testbench

//  Central stall/flush controller for the five-stage pipeline. Merges per-stage stall requests into the
//  6-bit stall vector used by PC, IF/ID, ID/EX, EX/MEM, MEM/WB and WB, and times the multi-cycle divider.

---
 rtl/pipe_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges stage stall requests, times the
// multi-cycle divider and turns exceptions, interrupts and ERET into a one-cycle redirect.
module pipe_ctrl #(
    parameter int          DIV_CYCLES = 32,
    parameter logic [31:0] EXC_VEC    = 32'h0000_0040
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        div_start,
    input  logic        stallreq_mem,
    input  logic        excpt_req,
    input  logic        eret_req,
    input  logic [31:0] mem_pc,
    input  logic [31:0] cp0_epc,
    input  logic [5:0]  int_i,
    input  logic [5:0]  int_mask,
    input  logic        int_en,
    output logic [5:0]  stall,
    output logic        flush,
    output logic        excpt,
    output logic [31:0] ejpc,
    output logic        epc_wr,
    output logic [31:0] epc_wdata,
    output logic        div_done
);

    localparam int CNT_W = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DIV, FLUSH} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             int_pend;
    logic             accept;
    logic             take_exc;

    // An event can only be taken while MEM is not stalled and no redirect is in flight.
    always_comb begin
        accept   = !stallreq_mem && (state != FLUSH) && (excpt_req || int_pend || eret_req);
        take_exc = excpt_req || int_pend;
    end

    always_comb begin
        stall = 6'b000000;
        if (state == FLUSH)
            stall = 6'b000000;
        else if (stallreq_mem)
            stall = 6'b011111;
        else if ((state == DIV) && (cnt != '0))
            stall = 6'b001111;
        else if (stallreq_ex)
            stall = 6'b001111;
        else if (stallreq_id)
            stall = 6'b000111;
    end

    // An accepted event aborts the divide, so the final cycle must not also signal completion.
    always_comb begin
        div_done = (state == DIV) && (cnt == '0) && !stallreq_mem && !accept;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            int_pend  <= 1'b0;
            flush     <= 1'b0;
            excpt     <= 1'b0;
            ejpc      <= 32'h0;
            epc_wr    <= 1'b0;
            epc_wdata <= 32'h0;
        end else begin
            int_pend  <= (|(int_i & int_mask)) & int_en;
            flush     <= 1'b0;
            excpt     <= 1'b0;
            ejpc      <= 32'h0;
            epc_wr    <= 1'b0;
            epc_wdata <= 32'h0;
            if (accept) begin
                state <= FLUSH;
                cnt   <= '0;
                flush <= 1'b1;
                excpt <= 1'b1;
                if (take_exc) begin
                    ejpc      <= EXC_VEC;
                    epc_wr    <= 1'b1;
                    epc_wdata <= mem_pc;
                end else begin
                    ejpc <= cp0_epc;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (div_start) begin
                            state <= DIV;
                            cnt   <= CNT_LOAD;
                        end
                    end
                    DIV: begin
                        // Counter holds while memory stalls the whole pipe.
                        if (!stallreq_mem) begin
                            if (cnt == '0)
                                state <= RUN;
                            else
                                cnt <= cnt - 1'b1;
                        end
                    end
                    FLUSH:   state <= RUN;
                    default: state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: fixed vector table, directed divide/abort/reset sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_pipe_ctrl;

    localparam int DIVC = 32;
    localparam logic [31:0] VEC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_id, stallreq_ex, div_start, stallreq_mem;
    logic        excpt_req, eret_req;
    logic [31:0] mem_pc, cp0_epc;
    logic [5:0]  int_i, int_mask;
    logic        int_en;
    logic [5:0]  stall;
    logic        flush, excpt, epc_wr, div_done;
    logic [31:0] ejpc, epc_wdata;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.DIV_CYCLES(DIVC), .EXC_VEC(VEC)) dut (
        .clk(clk), .rst(rst),
        .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex), .div_start(div_start),
        .stallreq_mem(stallreq_mem), .excpt_req(excpt_req), .eret_req(eret_req),
        .mem_pc(mem_pc), .cp0_epc(cp0_epc), .int_i(int_i), .int_mask(int_mask),
        .int_en(int_en), .stall(stall), .flush(flush), .excpt(excpt), .ejpc(ejpc),
        .epc_wr(epc_wr), .epc_wdata(epc_wdata), .div_done(div_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        id, ex, ds, mem, exc, eret;
        logic [31:0] pc, epc;
        logic [5:0]  intr, mask;
        logic        en;
        logic [5:0]  e_stall;
        logic        e_flush, e_excpt;
        logic [31:0] e_ejpc;
        logic        e_epc_wr;
        logic [31:0] e_wdata;
        logic        e_done;
    } vec_t;

    // Behavioural model: divide progress counted in elapsed cycles since issue.
    bit          m_in_flush, m_div_active, m_pend;
    int          m_elapsed;
    logic        x_flush, x_excpt, x_epc_wr;
    logic [31:0] x_ejpc, x_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_event();
        return !stallreq_mem && !m_in_flush && (excpt_req || m_pend || eret_req);
    endfunction

    function automatic logic [5:0] m_stall();
        if (m_in_flush) return 6'b000000;
        if (stallreq_mem) return 6'b011111;
        if ((m_div_active && m_elapsed < DIVC) || stallreq_ex) return 6'b001111;
        if (stallreq_id) return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic logic m_done();
        return m_div_active && (m_elapsed == DIVC) && !stallreq_mem && !m_event();
    endfunction

    task automatic model_check();
        chk("stall", {26'h0, stall}, {26'h0, m_stall()});
        chk("div_done", {31'h0, div_done}, {31'h0, m_done()});
        chk("flush", {31'h0, flush}, {31'h0, x_flush});
        chk("excpt", {31'h0, excpt}, {31'h0, x_excpt});
        chk("ejpc", ejpc, x_ejpc);
        chk("epc_wr", {31'h0, epc_wr}, {31'h0, x_epc_wr});
        chk("epc_wdata", epc_wdata, x_wdata);
    endtask

    task automatic model_adv();
        bit ev;
        ev = m_event();
        if (rst) begin
            m_in_flush = 0; m_div_active = 0; m_pend = 0; m_elapsed = 0;
            x_flush = 0; x_excpt = 0; x_epc_wr = 0; x_ejpc = 0; x_wdata = 0;
            return;
        end
        x_flush = ev; x_excpt = ev;
        x_epc_wr = ev && (excpt_req || m_pend);
        x_ejpc = !ev ? 32'h0 : ((excpt_req || m_pend) ? VEC : cp0_epc);
        x_wdata = x_epc_wr ? mem_pc : 32'h0;
        if (ev) begin
            m_in_flush = 1; m_div_active = 0;
        end else if (m_in_flush) begin
            m_in_flush = 0;
        end else if (m_div_active) begin
            if (!stallreq_mem) begin
                if (m_elapsed == DIVC) m_div_active = 0;
                else m_elapsed++;
            end
        end else if (div_start) begin
            m_div_active = 1; m_elapsed = 1;
        end
        m_pend = (|(int_i & int_mask)) && int_en;
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        model_adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; stallreq_id = 0; stallreq_ex = 0; div_start = 0; stallreq_mem = 0;
        excpt_req = 0; eret_req = 0; mem_pc = 0; cp0_epc = 0;
        int_i = 0; int_mask = 0; int_en = 0;
    endtask

    task automatic apply(input vec_t v);
        rst = 0;
        stallreq_id = v.id; stallreq_ex = v.ex; div_start = v.ds; stallreq_mem = v.mem;
        excpt_req = v.exc; eret_req = v.eret; mem_pc = v.pc; cp0_epc = v.epc;
        int_i = v.intr; int_mask = v.mask; int_en = v.en;
    endtask

    function automatic vec_t mk(input logic id, ex, ds, mem, exc, eret,
                                input logic [31:0] pc, epc, input logic [5:0] intr, mask,
                                input logic en, input logic [5:0] es, input logic ef, ee,
                                input logic [31:0] ej, input logic ew, input logic [31:0] ed,
                                input logic edn);
        vec_t v;
        v.id = id; v.ex = ex; v.ds = ds; v.mem = mem; v.exc = exc; v.eret = eret;
        v.pc = pc; v.epc = epc; v.intr = intr; v.mask = mask; v.en = en;
        v.e_stall = es; v.e_flush = ef; v.e_excpt = ee; v.e_ejpc = ej;
        v.e_epc_wr = ew; v.e_wdata = ed; v.e_done = edn;
        return v;
    endfunction

    vec_t tbl[$];
    int   done_seen;

    initial begin
        idle();
        rst = 1;
        m_in_flush = 0; m_div_active = 0; m_pend = 0; m_elapsed = 0;
        advance();
        advance();
        rst = 0;

        //        id ex ds mem exc eret pc      epc     intr mask en  stall    fl ex ejpc  ew wdata  done
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(1,0,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b000111,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,1,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b001111,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(1,1,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b001111,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(1,0,0,1,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b011111,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,1,0, 32'h120, 32'h0,   6'd0,6'd0,0, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b000000,1,1,32'h40, 1,32'h120,0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,0,1, 32'h0,   32'h200, 6'd0,6'd0,0, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b000000,1,1,32'h200,0,32'h0,  0));
        tbl.push_back(mk(0,0,0,1,1,0, 32'h88,  32'h0,   6'd0,6'd0,0, 6'b011111,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,1,0, 32'h88,  32'h0,   6'd0,6'd0,0, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,1,0, 32'h88,  32'h0,   6'd0,6'd0,0, 6'b000000,1,1,32'h40, 1,32'h88, 0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,1,1, 32'h300, 32'h200, 6'd0,6'd0,0, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b000000,1,1,32'h40, 1,32'h300,0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd4,6'd4,0, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd4,6'd4,0, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd4,6'd4,1, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h180, 32'h0,   6'd0,6'd4,1, 6'b000000,0,0,32'h0,  0,32'h0,  0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b000000,1,1,32'h40, 1,32'h180,0));
        tbl.push_back(mk(0,0,0,0,0,0, 32'h0,   32'h0,   6'd0,6'd0,0, 6'b000000,0,0,32'h0,  0,32'h0,  0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            sample();
            chk($sformatf("tbl%0d_stall", i), {26'h0, stall}, {26'h0, tbl[i].e_stall});
            chk($sformatf("tbl%0d_flush", i), {31'h0, flush}, {31'h0, tbl[i].e_flush});
            chk($sformatf("tbl%0d_excpt", i), {31'h0, excpt}, {31'h0, tbl[i].e_excpt});
            chk($sformatf("tbl%0d_ejpc", i), ejpc, tbl[i].e_ejpc);
            chk($sformatf("tbl%0d_epc_wr", i), {31'h0, epc_wr}, {31'h0, tbl[i].e_epc_wr});
            chk($sformatf("tbl%0d_wdata", i), epc_wdata, tbl[i].e_wdata);
            chk($sformatf("tbl%0d_done", i), {31'h0, div_done}, {31'h0, tbl[i].e_done});
            advance();
        end

        // Full divide with no interference.
        idle(); div_start = 1;
        sample(); advance();
        div_start = 0;
        for (int k = 1; k <= DIVC + 1; k++) begin
            sample();
            if (k < DIVC) begin
                chk("div_hold_stall", {26'h0, stall}, 32'h0F);
                chk("div_hold_done", {31'h0, div_done}, 32'h0);
            end else if (k == DIVC) begin
                chk("div_last_stall", {26'h0, stall}, 32'h0);
                chk("div_last_done", {31'h0, div_done}, 32'h1);
            end else begin
                chk("div_after_done", {31'h0, div_done}, 32'h0);
            end
            advance();
        end

        // Exception held behind a memory stall during a divide, then aborting it.
        idle(); div_start = 1;
        sample(); advance();
        div_start = 0;
        repeat (5) begin sample(); advance(); end
        stallreq_mem = 1; excpt_req = 1; mem_pc = 32'h2A0;
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("memhold_stall", {26'h0, stall}, 32'h1F);
            chk("memhold_excpt", {31'h0, excpt}, 32'h0);
            advance();
        end
        stallreq_mem = 0;
        sample();
        chk("abort_take_stall", {26'h0, stall}, 32'h0F);
        advance();
        excpt_req = 0;
        sample();
        chk("abort_flush", {31'h0, flush}, 32'h1);
        chk("abort_wdata", epc_wdata, 32'h2A0);
        advance();
        done_seen = 0;
        repeat (DIVC + 8) begin
            sample();
            if (div_done) done_seen++;
            advance();
        end
        chk("abort_no_done", done_seen, 32'h0);

        // Reset in the middle of a divide.
        idle(); div_start = 1;
        sample(); advance();
        div_start = 0;
        repeat (4) begin sample(); advance(); end
        rst = 1;
        advance();
        rst = 0;
        sample();
        chk("rst_stall", {26'h0, stall}, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_excpt", {31'h0, excpt}, 32'h0);
        chk("rst_ejpc", ejpc, 32'h0);
        chk("rst_epc_wr", {31'h0, epc_wr}, 32'h0);
        advance();
        done_seen = 0;
        repeat (DIVC + 4) begin
            sample();
            if (div_done) done_seen++;
            advance();
        end
        chk("rst_no_done", done_seen, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst          = ($urandom_range(0, 299) == 0);
            stallreq_id  = ($urandom_range(0, 5) == 0);
            stallreq_ex  = ($urandom_range(0, 7) == 0);
            div_start    = ($urandom_range(0, 9) == 0);
            stallreq_mem = ($urandom_range(0, 5) == 0);
            excpt_req    = ($urandom_range(0, 39) == 0);
            eret_req     = ($urandom_range(0, 39) == 0);
            mem_pc       = $urandom;
            cp0_epc      = $urandom;
            int_i        = 6'($urandom);
            int_mask     = 6'($urandom);
            int_en       = ($urandom_range(0, 19) == 0);
            sample();
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
